// File: rtl/mult_pkg.sv
// Shared definitions for the sequential chunked multiplier.
//   state_t : controller state encoding (IDLE, MUL, FIX), also used by the bench
//   idx_w   : width of an index counter able to address n slices (min 1 bit)
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_param_if.sv
// Request/response bundle of the sequential multiplier.
//   start, signed_mode, a, b : request, driven by the master, sampled in IDLE
//   busy, done, product      : status and result, driven by the slave (multiplier)
interface mult_seq_param_if #(
  parameter int A_W = 32,
  parameter int B_W = 32
);

  logic               start;
  logic               signed_mode;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic               busy;
  logic               done;
  logic [A_W+B_W-1:0] product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult_seq_param_fsm.sv
// Controller of the sequential multiplier.
//   clk, reset : clock, asynchronous active-high reset
//   start      : request; only honoured in IDLE
//   state      : current state, used by the datapath to pick its action
//   a_sel      : A slice index (inner loop)
//   b_sel      : B slice index (outer loop)
//   busy, done : registered status; done pulses in the first IDLE cycle after FIX
module mult_seq_param_fsm
  import mult_pkg::*;
#(
  parameter int NA  = 4,
  parameter int NB  = 2,
  parameter int IAW = 2,
  parameter int IBW = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output state_t         state,
  output logic [IAW-1:0] a_sel,
  output logic [IBW-1:0] b_sel,
  output logic           busy,
  output logic           done
);

  state_t         state_reg;
  logic [IAW-1:0] a_sel_reg;
  logic [IBW-1:0] b_sel_reg;
  logic           busy_reg;
  logic           done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      a_sel_reg <= '0;
      b_sel_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= MUL;
            a_sel_reg <= '0;
            b_sel_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        MUL: begin
          // i runs fastest; the last (i, j) pair ends the accumulation
          if (a_sel_reg == IAW'(NA - 1)) begin
            a_sel_reg <= '0;
            if (b_sel_reg == IBW'(NB - 1)) begin
              b_sel_reg <= '0;
              state_reg <= FIX;
            end else begin
              b_sel_reg <= b_sel_reg + IBW'(1);
            end
          end else begin
            a_sel_reg <= a_sel_reg + IAW'(1);
          end
        end
        FIX: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_reg;
  assign a_sel = a_sel_reg;
  assign b_sel = b_sel_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: rtl/mult_seq_param.sv
// Sequential multiplier: one A_CHUNK x B_CHUNK partial product per cycle,
// sign-magnitude handling of two's-complement operands.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of mult_seq_param_if (start/signed_mode/a/b in,
//                busy/done/product out)
// Latency: start sampled at edge 0 -> busy in cycles 1..N+1, done in cycle N+2.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int A_W     = 32,
  parameter int B_W     = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input logic          clk,
  input logic          reset,
  mult_seq_param_if.slave bus
);

  localparam int NA  = A_W / A_CHUNK;
  localparam int NB  = B_W / B_CHUNK;
  localparam int N   = NA * NB;
  localparam int P_W = A_W + B_W;
  localparam int PPW = A_CHUNK + B_CHUNK;
  localparam int IAW = idx_w(NA);
  localparam int IBW = idx_w(NB);

  if (((A_W % A_CHUNK) != 0) || ((B_W % B_CHUNK) != 0) || (N < 2)) begin : g_bad_cfg
    $error("mult_seq_param: widths must split exactly into chunks and give at least two partial products");
  end

  state_t         state;
  logic [IAW-1:0] a_sel;
  logic [IBW-1:0] b_sel;
  logic           busy;
  logic           done;

  mult_seq_param_fsm #(
    .NA  (NA),
    .NB  (NB),
    .IAW (IAW),
    .IBW (IBW)
  ) u_fsm (
    .clk   (clk),
    .reset (reset),
    .start (bus.start),
    .state (state),
    .a_sel (a_sel),
    .b_sel (b_sel),
    .busy  (busy),
    .done  (done)
  );

  logic [A_W-1:0] a_mag_reg;
  logic [B_W-1:0] b_mag_reg;
  logic           sign_reg;
  logic [P_W-1:0] product_reg;

  // Magnitudes fit in W bits: negating the most negative value wraps to 2^(W-1),
  // which is exactly its magnitude when read as unsigned.
  logic           a_neg;
  logic           b_neg;
  logic [A_W-1:0] a_abs;
  logic [B_W-1:0] b_abs;

  assign a_neg = bus.signed_mode & bus.a[A_W-1];
  assign b_neg = bus.signed_mode & bus.b[B_W-1];
  assign a_abs = a_neg ? (A_W'(0) - bus.a) : bus.a;
  assign b_abs = b_neg ? (B_W'(0) - bus.b) : bus.b;

  // Slice select, partial product and alignment shift for the current (i, j)
  logic [31:0]        a_shift;
  logic [31:0]        b_shift;
  logic [A_CHUNK-1:0] a_slice;
  logic [B_CHUNK-1:0] b_slice;
  logic [PPW-1:0]     pp;
  logic [P_W-1:0]     pp_aligned;

  assign a_shift    = 32'(a_sel) * 32'(A_CHUNK);
  assign b_shift    = 32'(b_sel) * 32'(B_CHUNK);
  assign a_slice    = A_CHUNK'(a_mag_reg >> a_shift);
  assign b_slice    = B_CHUNK'(b_mag_reg >> b_shift);
  assign pp         = PPW'(a_slice) * PPW'(b_slice);
  assign pp_aligned = P_W'(pp) << (a_shift + b_shift);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag_reg   <= '0;
      b_mag_reg   <= '0;
      sign_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_mag_reg   <= a_abs;
            b_mag_reg   <= b_abs;
            sign_reg    <= a_neg ^ b_neg;
            product_reg <= '0;
          end
        end
        MUL: begin
          product_reg <= product_reg + pp_aligned;
        end
        FIX: begin
          if (sign_reg) begin
            product_reg <= P_W'(0) - product_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_reg;

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 SHALL have parameter A_W, default 32, width of operand A.
REQ-002 SHALL have parameter B_W, default 32, width of operand B.
REQ-003 SHALL have parameter A_CHUNK, default 8, A slice width per partial product.
REQ-004 SHALL have parameter B_CHUNK, default 16, B slice width per partial product.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request a multiplication; sampled only in IDLE.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-009 SHALL have port a  input  A_W  multiplicand; sampled with start.
REQ-010 SHALL have port b  input  B_W  multiplier; sampled with start.
REQ-011 SHALL have port busy  output  1  operation in progress (MUL or FIX).
REQ-012 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-013 SHALL have port product  output  A_W+B_W  result register.

Function
REQ-014 SHALL derive NA=A_W/A_CHUNK, NB=B_W/B_CHUNK, N=NA*NB, and SHALL fail elaboration unless both divisions are exact and N>=2.
REQ-015 SHALL implement states IDLE, MUL, FIX: IDLE->MUL on start; MUL->MUL while step<N-1; MUL->FIX at step N-1; FIX->IDLE unconditionally.
REQ-016 On start in IDLE, SHALL latch |a|, |b| (raw values when signed_mode=0), latch the sign flag (sign(a) XOR sign(b), 0 when unsigned), clear product, and zero both indices.
REQ-017 Magnitudes SHALL be held in A_W/B_W-bit unsigned registers; the most negative input (e.g. 0x80000000) SHALL yield magnitude 2^(W-1) without overflow.
REQ-018 In each MUL cycle, with A index i and B index j, SHALL add (A slice i * B slice j) << (i*A_CHUNK + j*B_CHUNK) into product, truncated to A_W+B_W bits.
REQ-019 Indices SHALL order i inner, j outer: i increments each cycle; on i=NA-1, i wraps to 0 and j increments.
REQ-020 In FIX, SHALL replace product with its two's-complement negation when the sign flag is 1, otherwise hold it.
REQ-021 done SHALL be registered and high exactly in the cycle after FIX (state IDLE), low otherwise.
REQ-022 Latency: with start sampled at edge 0, done SHALL be high during cycle N+2; busy SHALL be high during cycles 1..N+1.
REQ-023 start while busy SHALL be ignored, with no effect on operands or product.
REQ-024 start during the done cycle SHALL be accepted (back-to-back); done still pulses for the finished result.
REQ-025 product SHALL hold its value in IDLE until the next accepted start; intermediate values during busy are not valid.

Reset
REQ-026 Reset SHALL force state IDLE and clear busy, done, product, indices, operand registers, and sign flag immediately, including mid-operation.
REQ-027 After reset deassertion, the first start SHALL behave identically to one issued after a completed operation.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum typedef (IDLE, MUL, FIX) shared by the FSM and bench.
REQ-029 Controller SHALL be sub-module mult_seq_param_fsm: state, indices, busy, done, and slice selects; datapath (magnitude, slice mux, shifter, accumulator, negate) SHALL stay in the top.

Verification
REQ-030 Defaults, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> product 0xFFFFFFFE00000001, done high only in cycle 10, busy cycles 1-9.
REQ-031 Defaults, signed, a=0xFFFFFFFF (-1), b=0x00000002 -> product 0xFFFFFFFFFFFFFFFE; a=b=0x80000000 -> 0x4000000000000000.
REQ-032 start held high through the operation -> single result at cycle 10; start in the done cycle -> second result at cycle 20.
REQ-033 reset pulsed during cycle 4 of an operation -> busy=0, done=0, product=0 at once; next op 3x5 unsigned -> 15.
REQ-034 A_W=16, B_W=8, A_CHUNK=4, B_CHUNK=8, unsigned a=0xABCD, b=0xEF -> product 0xA06463, done in cycle 6.
